id_stage_pipelined: RTL and testbench
=====================================

Name: id_stage_pipelined

Overview:
- Parametrised instruction-decode stage with its own ID/EX pipeline register, register file, load-use/branch hazard detection and EX/MEM forwarding into the branch comparator.
- Sits between the IF/ID register and the EX stage of the MIPS32 pipeline.
- Generalises data and PC width, register count, and owns stall generation instead of taking Data_Hazard externally.

Parameters:
DATA_W, 32, register/operand width (>=16)
PC_W, 10, instruction-address width
NREGS, 32, architectural registers (power of 2); AW = clog2(NREGS)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pc_plus4  in  PC_W  PC+4 of instruction in ID
instr  in  32  instruction in ID
if_flush  in  1  squash instruction in ID (control hazard)
wb_reg_write  in  1  MEM/WB write enable
wb_addr  in  AW  MEM/WB destination
wb_data  in  DATA_W  MEM/WB write-back data
exm_reg_write  in  1  EX/MEM write enable
exm_mem_read  in  1  EX/MEM is a load
exm_dest  in  AW  EX/MEM destination
exm_alu_result  in  DATA_W  EX/MEM ALU result (forward source)
stall  out  1  hold PC and IF/ID (combinational)
branch_taken  out  1  redirect to branch_address (combinational)
branch_address  out  PC_W  pc_plus4 + (sext(imm)<<2), truncated
jump  out  1  redirect to jump_address (combinational)
jump_address  out  PC_W  {instr[25:0],2'b00} truncated to PC_W
ide_reg1, ide_reg2  out  DATA_W  registered operands
ide_imm  out  DATA_W  registered sign-extended imm
ide_rs, ide_rt, ide_dest  out  AW  registered register addresses
ide_mem_to_reg, ide_mem_read, ide_mem_write, ide_alu_src, ide_reg_write  out  1  registered controls
ide_alu_op  out  2  registered ALU op

Behaviour:
- Reset low: all ide_* outputs 0, all registers 0, async; stall/branch_taken/jump follow from cleared state.
- Decode: 0x00 R-type (reg_dst=1, alu_op=10, reg_write); 0x23 lw (alu_src, mem_read, mem_to_reg, reg_write, op 00); 0x2B sw (alu_src, mem_write, op 00); 0x04 beq (branch, op 01); 0x08 addi (alu_src, reg_write, op 00); 0x02 j (jump). Others: all controls 0.
- ide_dest = instr[15:11] if reg_dst else instr[20:16].
- Register file: write on rising edge when wb_reg_write && wb_addr!=0; reg 0 reads 0 always; same-cycle write/read of same address returns wb_data (write-through bypass).
- Load-use stall: ide_mem_read && ide_dest!=0 && (ide_dest==rs || ide_dest==rt).
- Branch stall (branch only): ide_reg_write && ide_dest!=0 matching rs/rt; or exm_mem_read && exm_dest!=0 matching rs/rt.
- Branch operand forwarding: if exm_reg_write && !exm_mem_read && exm_dest!=0 && exm_dest==rs/rt, use exm_alu_result for that operand; else register file.
- branch_taken = branch && operands equal && !stall && !if_flush. jump = jump-decode && !stall && !if_flush.
- ID/EX update every cycle. If stall || if_flush: all controls loaded 0 (bubble); data fields still loaded. Otherwise all fields loaded from decode. Latency: ID outputs one cycle.
- stall and if_flush together: bubble, stall still asserted.
- Branch address arithmetic modulo 2^PC_W; no overflow flag.

Optional Feature:
- BNE_EN defined: opcode 0x05 decodes as bne (branch, op 01, taken when operands differ), with the same stall/forward rules.
- Undefined: 0x05 decodes as all-zero controls.

Decomposition:
- Package id_pkg: opcode constants, ALU-op encodings, control-bundle struct typedef.
- Sub-module regfile_param (NREGS x DATA_W, 2R1W, write-through, async active-low clear).
- Decode and hazard logic stay inline.

Test Plan:
- lw r2,0(r1) then add r3,r2,r4 -> stall=1 one cycle, bubble (all ide_ controls 0), add issues next cycle with ide_reg1=r2 value.
- r5=7 via wb and beq r5,r6 with r6=7 in same cycle -> write-through; branch_taken=1; branch_address=pc_plus4+(imm<<2), e.g. pc_plus4=0x10, imm=3 -> 0x1C.
- exm_dest=5, exm_alu_result=9, exm_reg_write=1, beq r5,r0 -> not taken; exm_alu_result=0 -> taken without stall.
- addi r7 in ID/EX then beq r7,r0 -> stall=1, branch_taken=0 for one cycle.
- if_flush=1 with j 0x40 -> jump=0, next ide_ controls 0; reset low mid-stream -> all ide_ outputs 0 immediately.
- BNE_EN: bne r1,r2 with values 1/2 -> taken; without macro -> controls 0, not taken.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU-op codes, control bundle.
// Optional bne support is enabled by defining BNE_EN; otherwise opcode 0x05 decodes to all-zero controls.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_BR    = 2'b01,
        ALU_RTYPE = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    branch_ne;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [5:0] opcode);
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_RTYPE; end
            OP_LW:    begin c.alu_src = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            OP_SW:    begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
            OP_BEQ:   begin c.branch = 1'b1; c.alu_op = ALU_BR; end
            OP_BNE:   begin
`ifdef BNE_EN
                c.branch    = 1'b1;
                c.branch_ne = 1'b1;
                c.alu_op    = ALU_BR;
`else
                c = '0;
`endif
            end
            OP_ADDI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
            OP_J:     c.jump = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_pipelined_if.sv
// Bundle of the ID stage's pipeline-facing signals: IF/ID inputs, WB and EX/MEM feedback, ID/EX outputs.
// The master modport drives the stage inputs; the slave modport is the ID stage itself.
interface id_stage_pipelined_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 10,
    parameter int NREGS  = 32
);
    localparam int AW = $clog2(NREGS);

    logic [PC_W-1:0]   pc_plus4;
    logic [31:0]       instr;
    logic              if_flush;
    logic              wb_reg_write;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              exm_reg_write;
    logic              exm_mem_read;
    logic [AW-1:0]     exm_dest;
    logic [DATA_W-1:0] exm_alu_result;

    logic              stall;
    logic              branch_taken;
    logic [PC_W-1:0]   branch_address;
    logic              jump;
    logic [PC_W-1:0]   jump_address;
    logic [DATA_W-1:0] ide_reg1;
    logic [DATA_W-1:0] ide_reg2;
    logic [DATA_W-1:0] ide_imm;
    logic [AW-1:0]     ide_rs;
    logic [AW-1:0]     ide_rt;
    logic [AW-1:0]     ide_dest;
    logic              ide_mem_to_reg;
    logic              ide_mem_read;
    logic              ide_mem_write;
    logic              ide_alu_src;
    logic              ide_reg_write;
    logic [1:0]        ide_alu_op;

    modport master (
        output pc_plus4, instr, if_flush, wb_reg_write, wb_addr, wb_data,
               exm_reg_write, exm_mem_read, exm_dest, exm_alu_result,
        input  stall, branch_taken, branch_address, jump, jump_address,
               ide_reg1, ide_reg2, ide_imm, ide_rs, ide_rt, ide_dest,
               ide_mem_to_reg, ide_mem_read, ide_mem_write, ide_alu_src, ide_reg_write, ide_alu_op
    );

    modport slave (
        input  pc_plus4, instr, if_flush, wb_reg_write, wb_addr, wb_data,
               exm_reg_write, exm_mem_read, exm_dest, exm_alu_result,
        output stall, branch_taken, branch_address, jump, jump_address,
               ide_reg1, ide_reg2, ide_imm, ide_rs, ide_rt, ide_dest,
               ide_mem_to_reg, ide_mem_read, ide_mem_write, ide_alu_src, ide_reg_write, ide_alu_op
    );

endinterface

// File: rtl/regfile_param.sv
// NREGS x DATA_W register file, two async read ports, one write port; r0 is hardwired to zero.
// Reads see a same-cycle write (write-through); no backpressure.
module regfile_param #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0)               ? '0    :
                     (we && raddr_a == waddr)      ? wdata : mem[raddr_a];
    assign rdata_b = (raddr_b == '0)               ? '0    :
                     (we && raddr_b == waddr)      ? wdata : mem[raddr_b];

endmodule

// File: rtl/id_stage_pipelined.sv
// MIPS32 decode stage with register file, hazard detection, branch forwarding and ID/EX register.
// Latency: ID/EX outputs one cycle; stall/branch/jump are combinational. Stall or flush inserts a bubble.
// BNE_EN adds bne (opcode 0x05) decoding.
module id_stage_pipelined
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 10,
    parameter int NREGS  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    id_stage_pipelined_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    ctrl_t             ctl;
    logic [AW-1:0]     rs, rt, rd, dest;
    logic [DATA_W-1:0] rf_a, rf_b, op_a, op_b, imm;
    logic              ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic              load_use, br_stall, stall_i, bubble, ops_eq;

    assign ctl  = decode(bus.instr[31:26]);
    assign rs   = AW'(bus.instr[25:21]);
    assign rt   = AW'(bus.instr[20:16]);
    assign rd   = AW'(bus.instr[15:11]);
    assign dest = ctl.reg_dst ? rd : rt;
    assign imm  = DATA_W'($signed(bus.instr[15:0]));

    regfile_param #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(AW)) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (bus.wb_reg_write),
        .waddr   (bus.wb_addr),
        .wdata   (bus.wb_data),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    assign ex_hit_rs  = (bus.ide_dest != '0) && (bus.ide_dest == rs);
    assign ex_hit_rt  = (bus.ide_dest != '0) && (bus.ide_dest == rt);
    assign mem_hit_rs = (bus.exm_dest != '0) && (bus.exm_dest == rs);
    assign mem_hit_rt = (bus.exm_dest != '0) && (bus.exm_dest == rt);

    // Branches resolve in ID, so any result not yet available as an ALU value must stall.
    assign load_use = bus.ide_mem_read && (ex_hit_rs || ex_hit_rt);
    assign br_stall = ctl.branch &&
                      ((bus.ide_reg_write && (ex_hit_rs || ex_hit_rt)) ||
                       (bus.exm_mem_read  && (mem_hit_rs || mem_hit_rt)));
    assign stall_i  = load_use || br_stall;
    assign bubble   = stall_i || bus.if_flush;

    assign op_a   = (bus.exm_reg_write && !bus.exm_mem_read && mem_hit_rs) ? bus.exm_alu_result : rf_a;
    assign op_b   = (bus.exm_reg_write && !bus.exm_mem_read && mem_hit_rt) ? bus.exm_alu_result : rf_b;
    assign ops_eq = (op_a == op_b);

    assign bus.stall          = stall_i;
    assign bus.branch_taken   = ctl.branch && (ops_eq ^ ctl.branch_ne) && !bubble;
    assign bus.jump           = ctl.jump && !bubble;
    assign bus.branch_address = bus.pc_plus4 + PC_W'($signed({bus.instr[15:0], 2'b00}));
    assign bus.jump_address   = PC_W'({bus.instr[25:0], 2'b00});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.ide_reg1       <= '0;
            bus.ide_reg2       <= '0;
            bus.ide_imm        <= '0;
            bus.ide_rs         <= '0;
            bus.ide_rt         <= '0;
            bus.ide_dest       <= '0;
            bus.ide_mem_to_reg <= 1'b0;
            bus.ide_mem_read   <= 1'b0;
            bus.ide_mem_write  <= 1'b0;
            bus.ide_alu_src    <= 1'b0;
            bus.ide_reg_write  <= 1'b0;
            bus.ide_alu_op     <= 2'b00;
        end else begin
            bus.ide_reg1       <= rf_a;
            bus.ide_reg2       <= rf_b;
            bus.ide_imm        <= imm;
            bus.ide_rs         <= rs;
            bus.ide_rt         <= rt;
            bus.ide_dest       <= dest;
            bus.ide_mem_to_reg <= ctl.mem_to_reg && !bubble;
            bus.ide_mem_read   <= ctl.mem_read   && !bubble;
            bus.ide_mem_write  <= ctl.mem_write  && !bubble;
            bus.ide_alu_src    <= ctl.alu_src    && !bubble;
            bus.ide_reg_write  <= ctl.reg_write  && !bubble;
            bus.ide_alu_op     <= bubble ? 2'b00 : ctl.alu_op;
        end
    end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench for id_stage_pipelined: directed hazard scenarios then randomized traffic vs a reference model.
module tb_id_stage_pipelined;

    localparam int DATA_W = 32;
    localparam int PC_W   = 10;
    localparam int NREGS  = 32;
    localparam int AW     = 5;
    localparam logic [31:0] NOPZ = 32'hFC00_0000;  // opcode 0x3F: no controls, r0 operands

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    id_stage_pipelined_if #(.DATA_W(DATA_W), .PC_W(PC_W), .NREGS(NREGS)) bus ();
    id_stage_pipelined #(.DATA_W(DATA_W), .PC_W(PC_W), .NREGS(NREGS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] reg1, reg2, imm;
        logic [AW-1:0]     rs, rt, dest;
        logic              mtr, mr, mw, as, rw;
        logic [1:0]        aop;
    } ide_t;

    typedef struct {
        logic            stall, bt, jmp;
        logic [PC_W-1:0] ba, ja;
        ide_t            ide;
    } exp_t;

    exp_t              q[$];
    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] m_regs [NREGS];
    ide_t              m_ide;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ide_t ide_zero();
        ide_t z;
        z.reg1 = '0; z.reg2 = '0; z.imm = '0; z.rs = '0; z.rt = '0; z.dest = '0;
        z.mtr = 0; z.mr = 0; z.mw = 0; z.as = 0; z.rw = 0; z.aop = 2'd0;
        return z;
    endfunction

    function automatic logic [31:0] mk_i(input int op, input int rs, input int rt, input int imm);
        logic [31:0] w;
        w = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
        return w;
    endfunction

    function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd);
        return mk_i(0, rs, rt, (rd << 11) | 'h20);
    endfunction

    function automatic logic [DATA_W-1:0] mread(input logic [AW-1:0] r, input logic wwe,
                                                input logic [AW-1:0] wa, input logic [DATA_W-1:0] wd);
        if (r == 0) return '0;
        if (wwe && wa == r) return wd;
        return m_regs[r];
    endfunction

    task automatic step(input logic [31:0] ins, input logic [PC_W-1:0] pc, input logic fl,
                        input logic wwe, input logic [AW-1:0] wa, input logic [DATA_W-1:0] wd,
                        input logic xwe, input logic xmr, input logic [AW-1:0] xd,
                        input logic [DATA_W-1:0] xr);
        exp_t e;
        logic [AW-1:0] rs, rt, rd, dst;
        logic [DATA_W-1:0] va, vb, fa, fb;
        logic mtr, mr, mw, as, rw, rdst, br, bne, jmp, lu, bs, st;
        logic [1:0] aop;
        @(posedge clk);
        #1;
        bus.instr = ins; bus.pc_plus4 = pc; bus.if_flush = fl;
        bus.wb_reg_write = wwe; bus.wb_addr = wa; bus.wb_data = wd;
        bus.exm_reg_write = xwe; bus.exm_mem_read = xmr; bus.exm_dest = xd; bus.exm_alu_result = xr;

        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        {mtr, mr, mw, as, rw, rdst, br, bne, jmp} = '0;
        aop = 2'd0;
        case (ins[31:26])
            6'h00: begin rdst = 1; rw = 1; aop = 2'd2; end
            6'h23: begin as = 1; mr = 1; mtr = 1; rw = 1; end
            6'h2B: begin as = 1; mw = 1; end
            6'h04: begin br = 1; aop = 2'd1; end
            6'h08: begin as = 1; rw = 1; end
            6'h02: jmp = 1;
`ifdef BNE_EN
            6'h05: begin br = 1; bne = 1; aop = 2'd1; end
`endif
            default: ;
        endcase
        dst = rdst ? rd : rt;
        va  = mread(rs, wwe, wa, wd);
        vb  = mread(rt, wwe, wa, wd);
        fa  = (xwe && !xmr && xd != 0 && xd == rs) ? xr : va;
        fb  = (xwe && !xmr && xd != 0 && xd == rt) ? xr : vb;
        lu  = m_ide.mr && m_ide.dest != 0 && (m_ide.dest == rs || m_ide.dest == rt);
        bs  = br && ((m_ide.rw && m_ide.dest != 0 && (m_ide.dest == rs || m_ide.dest == rt)) ||
                     (xmr && xd != 0 && (xd == rs || xd == rt)));
        st  = lu || bs;

        e.stall = st;
        e.bt    = br && ((fa == fb) != bne) && !st && !fl;
        e.jmp   = jmp && !st && !fl;
        e.ba    = PC_W'(int'(pc) + 4 * int'($signed(ins[15:0])));
        e.ja    = PC_W'(longint'(ins[25:0]) * 4);
        e.ide   = m_ide;
        q.push_back(e);

        if (wwe && wa != 0) m_regs[wa] = wd;
        m_ide.reg1 = va; m_ide.reg2 = vb;
        m_ide.imm  = DATA_W'(int'($signed(ins[15:0])));
        m_ide.rs = rs; m_ide.rt = rt; m_ide.dest = dst;
        if (st || fl) begin
            m_ide.mtr = 0; m_ide.mr = 0; m_ide.mw = 0; m_ide.as = 0; m_ide.rw = 0; m_ide.aop = 2'd0;
        end else begin
            m_ide.mtr = mtr; m_ide.mr = mr; m_ide.mw = mw; m_ide.as = as; m_ide.rw = rw; m_ide.aop = aop;
        end
    endtask

    // Asynchronous reset in the middle of a cycle; idle inputs keep the next edge a no-op.
    task automatic do_reset();
        @(posedge clk);
        #1;
        bus.instr = NOPZ; bus.pc_plus4 = '0; bus.if_flush = 0;
        bus.wb_reg_write = 0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.exm_reg_write = 0; bus.exm_mem_read = 0; bus.exm_dest = '0; bus.exm_alu_result = '0;
        reset = 1'b0;
        #1;
        chk("rst_reg1", 64'(bus.ide_reg1), 64'd0);
        chk("rst_reg2", 64'(bus.ide_reg2), 64'd0);
        chk("rst_imm",  64'(bus.ide_imm),  64'd0);
        chk("rst_dest", 64'(bus.ide_dest), 64'd0);
        chk("rst_ctrl", 64'({bus.ide_mem_to_reg, bus.ide_mem_read, bus.ide_mem_write,
                             bus.ide_alu_src, bus.ide_reg_write, bus.ide_alu_op, bus.ide_rs, bus.ide_rt}), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_ide = ide_zero();
        #1;
        reset = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall",          64'(bus.stall),          64'(e.stall));
                chk("branch_taken",   64'(bus.branch_taken),   64'(e.bt));
                chk("jump",           64'(bus.jump),           64'(e.jmp));
                chk("branch_address", 64'(bus.branch_address), 64'(e.ba));
                chk("jump_address",   64'(bus.jump_address),   64'(e.ja));
                chk("ide_reg1",       64'(bus.ide_reg1),       64'(e.ide.reg1));
                chk("ide_reg2",       64'(bus.ide_reg2),       64'(e.ide.reg2));
                chk("ide_imm",        64'(bus.ide_imm),        64'(e.ide.imm));
                chk("ide_rs",         64'(bus.ide_rs),         64'(e.ide.rs));
                chk("ide_rt",         64'(bus.ide_rt),         64'(e.ide.rt));
                chk("ide_dest",       64'(bus.ide_dest),       64'(e.ide.dest));
                chk("ide_mem_to_reg", 64'(bus.ide_mem_to_reg), 64'(e.ide.mtr));
                chk("ide_mem_read",   64'(bus.ide_mem_read),   64'(e.ide.mr));
                chk("ide_mem_write",  64'(bus.ide_mem_write),  64'(e.ide.mw));
                chk("ide_alu_src",    64'(bus.ide_alu_src),    64'(e.ide.as));
                chk("ide_reg_write",  64'(bus.ide_reg_write),  64'(e.ide.rw));
                chk("ide_alu_op",     64'(bus.ide_alu_op),     64'(e.ide.aop));
            end
        end
    end

    initial begin : driver
        int ops[8] = '{0, 'h23, 'h2B, 4, 8, 2, 5, 'h3F};
        logic [31:0] ins;
        do_reset();

        // load-use: lw r2,0(r1); add r3,r2,r4 stalls once then issues with r2's value
        step(NOPZ, 10'h0, 0, 1, 5'd4, 32'h44, 0, 0, 5'd0, 32'h0);
        step(mk_i('h23, 1, 2, 0), 10'h4, 0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        step(mk_r(2, 4, 3), 10'h8, 0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        step(mk_r(2, 4, 3), 10'h8, 0, 1, 5'd2, 32'h55, 0, 0, 5'd0, 32'h0);
        // write-through into beq r5,r6 at pc_plus4=0x10, imm=3
        step(NOPZ, 10'hC, 0, 1, 5'd6, 32'h7, 0, 0, 5'd0, 32'h0);
        step(mk_i(4, 5, 6, 3), 10'h10, 0, 1, 5'd5, 32'h7, 0, 0, 5'd0, 32'h0);
        // EX/MEM forwarding into comparator
        step(mk_i(4, 5, 0, 3), 10'h14, 0, 0, 5'd0, 32'h0, 1, 0, 5'd5, 32'h9);
        step(mk_i(4, 5, 0, 3), 10'h14, 0, 0, 5'd0, 32'h0, 1, 0, 5'd5, 32'h0);
        // addi r7 in ID/EX then beq r7,r0 stalls
        step(mk_i(8, 0, 7, 1), 10'h18, 0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        step(mk_i(4, 7, 0, 2), 10'h1C, 0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        // flushed jump
        step({6'h02, 26'h10}, 10'h20, 1, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        step(NOPZ, 10'h24, 0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        // bne r1,r2 with 1/2
        step(NOPZ, 10'h28, 0, 1, 5'd1, 32'h1, 0, 0, 5'd0, 32'h0);
        step(NOPZ, 10'h2C, 0, 1, 5'd2, 32'h2, 0, 0, 5'd0, 32'h0);
        step(mk_i(5, 1, 2, 1), 10'h30, 0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
        step(NOPZ, 10'h34, 0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            ins = mk_i(ops[$urandom_range(0, 7)], $urandom_range(0, 7), $urandom_range(0, 7),
                       int'($urandom_range(0, 65535)));
            if ($urandom_range(0, 3) == 0) ins[15:11] = 5'($urandom_range(0, 7));
            step(ins, PC_W'($urandom), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 7)), DATA_W'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 7)),
                 DATA_W'($urandom_range(0, 3)));
        end

        for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
